// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write-port arbiter with burst lock for the async FIFO write side
module fifo_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          wclk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          full,
    output logic                          signal_write,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [$clog2(N_REQ)-1:0]      owner,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          wr_count,
    output logic [CNT_WIDTH-1:0]          stall_count
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [OW-1:0]   last;
    logic [OW-1:0]   next_last;
    logic [OW-1:0]   next_owner;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   next_burst;
    logic            rr_found;
    logic [OW-1:0]   rr_idx;
    logic            grant;
    logic [OW-1:0]   grant_idx;
    logic            do_arb;
    logic            stall;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!rr_found && req[(int'(last) + i) % N_REQ]) begin
                rr_found = 1'b1;
                rr_idx   = OW'((int'(last) + i) % N_REQ);
            end
        end
    end

    // Next-state and grant decision; a released burst falls through to arbitration in the same cycle.
    always_comb begin
        next_state = state;
        next_last  = last;
        next_owner = owner;
        next_burst = burst_cnt;
        grant      = 1'b0;
        grant_idx  = owner;
        do_arb     = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: do_arb = 1'b1;
                BURST: begin
                    if (req[owner]) begin
                        // Full stalls the owner without dropping the lock or the burst count.
                        if (!full) begin
                            grant      = 1'b1;
                            grant_idx  = owner;
                            next_burst = burst_cnt + BW'(1);
                            if ((burst_cnt + BW'(1)) == BW'(MAX_BURST))
                                next_state = IDLE;
                        end
                    end else begin
                        do_arb = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
            if (do_arb) begin
                if (rr_found && !full) begin
                    grant      = 1'b1;
                    grant_idx  = rr_idx;
                    next_last  = rr_idx;
                    next_owner = rr_idx;
                    next_burst = BW'(1);
                    next_state = (MAX_BURST > 1) ? BURST : IDLE;
                end else begin
                    next_state = IDLE;
                end
            end
        end
        if (rst)
            grant = 1'b0;
    end

    // Write-port outputs driven straight from the grant decision.
    always_comb begin
        gnt            = '0;
        gnt[grant_idx] = grant;
        signal_write   = grant;
        write_data     = grant ? req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign busy  = (state == BURST);
    assign stall = enable && (|req) && full;

    // Arbiter state registers.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= OW'(N_REQ - 1);
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            last      <= next_last;
            owner     <= next_owner;
            burst_cnt <= next_burst;
        end
    end

    // Statistics: writes wrap, stalls saturate.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (grant)
                wr_count <= wr_count + CNT_WIDTH'(1);
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed and randomized checks of fifo_write_arbiter
module tb_fifo_write_arbiter;

    logic        wclk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;

    logic [3:0]  gnt_w   [2];
    logic        sw_w    [2];
    logic [7:0]  wd_w    [2];
    logic [1:0]  own_w   [2];
    logic        busy_w  [2];
    logic [15:0] wc_w    [2];
    logic [15:0] sc_w    [2];

    logic [7:0]  data_of [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(16)) dut_b4 (
        .wclk(wclk), .rst(rst), .enable(enable), .req(req), .req_data(req_data),
        .gnt(gnt_w[0]), .full(full), .signal_write(sw_w[0]), .write_data(wd_w[0]),
        .owner(own_w[0]), .busy(busy_w[0]), .wr_count(wc_w[0]), .stall_count(sc_w[0])
    );

    fifo_write_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1), .CNT_WIDTH(16)) dut_b1 (
        .wclk(wclk), .rst(rst), .enable(enable), .req(req), .req_data(req_data),
        .gnt(gnt_w[1]), .full(full), .signal_write(sw_w[1]), .write_data(wd_w[1]),
        .owner(own_w[1]), .busy(busy_w[1]), .wr_count(wc_w[1]), .stall_count(sc_w[1])
    );

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        req    = 4'b0000;
        full   = 1'b0;
        enable = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; enable = 1'b1; full = 1'b0;
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b0000) begin n_err++; $display("FAIL reset_gnt_b4: got %b expected 0000", gnt_w[0]); end
        n_cmp++; if (sw_w[0] !== 1'b0) begin n_err++; $display("FAIL reset_sw_b4: got %b expected 0", sw_w[0]); end
        n_cmp++; if (gnt_w[1] !== 4'b0000) begin n_err++; $display("FAIL reset_gnt_b1: got %b expected 0000", gnt_w[1]); end
        tick();
        rst = 1'b0; req = 4'b0000;
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b0000) begin n_err++; $display("FAIL idle_gnt: got %b expected 0000", gnt_w[0]); end
        n_cmp++; if (sw_w[0] !== 1'b0) begin n_err++; $display("FAIL idle_sw: got %b expected 0", sw_w[0]); end
        n_cmp++; if (wc_w[0] !== 16'd0) begin n_err++; $display("FAIL reset_wr_count: got %0d expected 0", wc_w[0]); end
        n_cmp++; if (sc_w[0] !== 16'd0) begin n_err++; $display("FAIL reset_stall_count: got %0d expected 0", sc_w[0]); end
        n_cmp++; if (own_w[0] !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d expected 0", own_w[0]); end
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_w[0]); end
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            @(negedge wclk);
            n_cmp++; if (gnt_w[1] !== exp_g) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_w[1], exp_g); end
            n_cmp++; if (wd_w[1] !== data_of[k % 4]) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", k, wd_w[1], data_of[k % 4]); end
            tick();
        end
        req = 4'b0000;
        @(negedge wclk);
        n_cmp++; if (wc_w[1] !== 16'd8) begin n_err++; $display("FAIL rr_wr_count: got %0d expected 8", wc_w[1]); end
        n_cmp++; if (busy_w[1] !== 1'b0) begin n_err++; $display("FAIL rr_busy: got %b expected 0", busy_w[1]); end
        tick();
    endtask

    task automatic test_burst;
        logic [3:0] exp_g    [6];
        logic       exp_busy [6];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
        exp_g[3] = 4'b0001; exp_g[4] = 4'b0010; exp_g[5] = 4'b0010;
        exp_busy[0] = 1'b0; exp_busy[1] = 1'b1; exp_busy[2] = 1'b1;
        exp_busy[3] = 1'b1; exp_busy[4] = 1'b0; exp_busy[5] = 1'b1;
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== exp_g[k]) begin n_err++; $display("FAIL burst_gnt[%0d]: got %b expected %b", k, gnt_w[0], exp_g[k]); end
            n_cmp++; if (busy_w[0] !== exp_busy[k]) begin n_err++; $display("FAIL burst_busy[%0d]: got %b expected %b", k, busy_w[0], exp_busy[k]); end
            tick();
        end
        req = 4'b0000;
        @(negedge wclk);
        n_cmp++; if (wc_w[0] !== 16'd6) begin n_err++; $display("FAIL burst_wr_count: got %0d expected 6", wc_w[0]); end
        n_cmp++; if (own_w[0] !== 2'd1) begin n_err++; $display("FAIL burst_owner: got %0d expected 1", own_w[0]); end
        tick();
    endtask

    task automatic test_stall;
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== 4'b0100) begin n_err++; $display("FAIL stall_pre_gnt[%0d]: got %b expected 0100", k, gnt_w[0]); end
            tick();
        end
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== 4'b0000) begin n_err++; $display("FAIL stall_gnt[%0d]: got %b expected 0000", k, gnt_w[0]); end
            n_cmp++; if (sw_w[0] !== 1'b0) begin n_err++; $display("FAIL stall_sw[%0d]: got %b expected 0", k, sw_w[0]); end
            n_cmp++; if (busy_w[0] !== 1'b1) begin n_err++; $display("FAIL stall_busy[%0d]: got %b expected 1", k, busy_w[0]); end
            tick();
        end
        full = 1'b0;
        req  = 4'b0110;
        @(negedge wclk);
        n_cmp++; if (sc_w[0] !== 16'd3) begin n_err++; $display("FAIL stall_count: got %0d expected 3", sc_w[0]); end
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== 4'b0100) begin n_err++; $display("FAIL stall_resume_gnt[%0d]: got %b expected 0100", k, gnt_w[0]); end
            tick();
        end
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b0010) begin n_err++; $display("FAIL stall_after_burst_gnt: got %b expected 0010", gnt_w[0]); end
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL stall_after_burst_busy: got %b expected 0", busy_w[0]); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_release;
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== 4'b0010) begin n_err++; $display("FAIL rel_pre_gnt[%0d]: got %b expected 0010", k, gnt_w[0]); end
            tick();
        end
        req = 4'b1000;
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b1000) begin n_err++; $display("FAIL rel_gnt: got %b expected 1000", gnt_w[0]); end
        n_cmp++; if (wd_w[0] !== data_of[3]) begin n_err++; $display("FAIL rel_data: got %h expected %h", wd_w[0], data_of[3]); end
        n_cmp++; if (sw_w[0] !== 1'b1) begin n_err++; $display("FAIL rel_sw: got %b expected 1", sw_w[0]); end
        tick();
        req = 4'b0000;
        @(negedge wclk);
        n_cmp++; if (own_w[0] !== 2'd3) begin n_err++; $display("FAIL rel_owner: got %0d expected 3", own_w[0]); end
        n_cmp++; if (busy_w[0] !== 1'b1) begin n_err++; $display("FAIL rel_busy: got %b expected 1", busy_w[0]); end
        tick();
    endtask

    task automatic test_random;
        int         writes [2];
        int         stalls;
        int         bad;
        logic [7:0] exp_wd;
        do_reset();
        writes[0] = 0; writes[1] = 0; stalls = 0;
        for (int c = 0; c < 400; c++) begin
            req    = 4'($urandom_range(0, 15));
            full   = ($urandom_range(0, 9) < 3);
            enable = ($urandom_range(0, 9) < 9);
            @(negedge wclk);
            if (enable && (|req) && full) stalls++;
            for (int d = 0; d < 2; d++) begin
                bad = 0;
                if ((gnt_w[d] != 4'b0000) && (full || !enable)) bad = 1;
                if ($countones(gnt_w[d]) > 1) bad = 1;
                if ((gnt_w[d] & ~req) != 4'b0000) bad = 1;
                if (enable && !full && (|req) && (gnt_w[d] == 4'b0000)) bad = 1;
                if (sw_w[d] !== (|gnt_w[d])) bad = 1;
                exp_wd = 8'h00;
                for (int i = 0; i < 4; i++) if (gnt_w[d][i]) exp_wd = data_of[i];
                if (wd_w[d] !== exp_wd) bad = 1;
                if (enable && !full && (|req)) writes[d]++;
                n_cmp++; if (bad != 0) begin n_err++; $display("FAIL random_cycle dut%0d c%0d: gnt=%b sw=%b wd=%h req=%b full=%b en=%b expected wd=%h", d, c, gnt_w[d], sw_w[d], wd_w[d], req, full, enable, exp_wd); end
            end
            tick();
        end
        req = 4'b0000; full = 1'b0; enable = 1'b1;
        @(negedge wclk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (wc_w[d] !== 16'(writes[d])) begin n_err++; $display("FAIL random_wr_count dut%0d: got %0d expected %0d", d, wc_w[d], writes[d]); end
            n_cmp++; if (sc_w[d] !== 16'(stalls)) begin n_err++; $display("FAIL random_stall_count dut%0d: got %0d expected %0d", d, sc_w[d], stalls); end
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            @(negedge wclk);
            n_cmp++; if (gnt_w[0] !== 4'b0100) begin n_err++; $display("FAIL mid_pre_gnt[%0d]: got %b expected 0100", k, gnt_w[0]); end
            tick();
        end
        rst = 1'b1;
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b0000) begin n_err++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt_w[0]); end
        n_cmp++; if (sw_w[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_sw: got %b expected 0", sw_w[0]); end
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy_w[0]); end
        n_cmp++; if (wc_w[0] !== 16'd0) begin n_err++; $display("FAIL mid_rst_wr_count: got %0d expected 0", wc_w[0]); end
        tick();
        rst = 1'b0;
        req = 4'b1111;
        @(negedge wclk);
        n_cmp++; if (gnt_w[0] !== 4'b0001) begin n_err++; $display("FAIL mid_first_gnt: got %b expected 0001", gnt_w[0]); end
        n_cmp++; if (wd_w[0] !== data_of[0]) begin n_err++; $display("FAIL mid_first_data: got %h expected %h", wd_w[0], data_of[0]); end
        tick();
        req = 4'b0000;
    endtask

    initial begin
        data_of[0] = 8'hA0; data_of[1] = 8'hB1; data_of[2] = 8'hC2; data_of[3] = 8'hD3;
        req_data = {data_of[3], data_of[2], data_of[1], data_of[0]};
        rst = 1'b1; enable = 1'b0; req = 4'b0000; full = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_burst();
        test_stall();
        test_release();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
